rob_multi: RTL

Parametrised reorder buffer for the out-of-order core, the generalised successor to the fixed 32-entry, three-writeback ROB. Depth and number of completion ports are parameters. Head/tail rollback on branch mispredict is precise. Retirement is in order, one instruction per cycle, and returns the old physical register to the rename free list. The block sits between dispatch (allocation) and the functional units (completion), and drives the global flush to dispatch, rename, the checkpoint unit and the FUs.

---
 rtl/rob_multi_if.sv | 61 ++++++
 rtl/rob_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rob_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rob_multi_if : dispatch, completion, branch and retire bundle of rob_multi |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface rob_multi_if #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int PREG_W = 7,
  parameter int NUM_WB = 3
);
  logic                    alloc_valid;
  logic                    alloc_ready;
  logic                    alloc_has_dest;
  logic [PREG_W-1:0]       alloc_pd_new;
  logic [PREG_W-1:0]       alloc_pd_old;
  logic [31:0]             alloc_pc;
  logic [TAG_W-1:0]        alloc_tag;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic                    br_mispredict;
  logic [TAG_W-1:0]        br_tag;
  logic                    retire_valid;
  logic                    retire_has_dest;
  logic [PREG_W-1:0]       retire_pd_old;
  logic [PREG_W-1:0]       retire_pd_new;
  logic [31:0]             retire_pc;
  logic [TAG_W-1:0]        retire_tag;
  logic                    flush_valid;
  logic [TAG_W-1:0]        flush_tag;
  logic [TAG_W-1:0]        head;
  logic [TAG_W:0]          count;
  logic                    full;
  logic                    empty;
`ifdef ROB_WB_CHECK_EN
  logic                    wb_err;
`endif

  modport master (
    output alloc_valid, alloc_has_dest, alloc_pd_new, alloc_pd_old, alloc_pc,
    output wb_valid, wb_tag, br_mispredict, br_tag,
`ifdef ROB_WB_CHECK_EN
    input  wb_err,
`endif
    input  alloc_ready, alloc_tag, retire_valid, retire_has_dest, retire_pd_old,
    input  retire_pd_new, retire_pc, retire_tag, flush_valid, flush_tag,
    input  head, count, full, empty
  );

  modport slave (
    input  alloc_valid, alloc_has_dest, alloc_pd_new, alloc_pd_old, alloc_pc,
    input  wb_valid, wb_tag, br_mispredict, br_tag,
`ifdef ROB_WB_CHECK_EN
    output wb_err,
`endif
    output alloc_ready, alloc_tag, retire_valid, retire_has_dest, retire_pd_old,
    output retire_pd_new, retire_pc, retire_tag, flush_valid, flush_tag,
    output head, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/rob_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rob_multi : parametrised reorder buffer, NUM_WB completion ports, precise  |
// |             mispredict rollback, in-order single retire.                   |
// |             Optional ROB_WB_CHECK_EN adds sticky wb_err.                   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module rob_multi #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = $clog2(DEPTH),
  parameter int PREG_W = 7,
  parameter int NUM_WB = 3
) (
  input  logic       clk,
  input  logic       reset,
  rob_multi_if.slave bus
);
  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  has_dest_q, has_dest_d;
  logic [PREG_W-1:0] pd_new_q [DEPTH];
  logic [PREG_W-1:0] pd_new_d [DEPTH];
  logic [PREG_W-1:0] pd_old_q [DEPTH];
  logic [PREG_W-1:0] pd_old_d [DEPTH];
  logic [31:0]       pc_q [DEPTH];
  logic [31:0]       pc_d [DEPTH];
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic              flush_valid_q, flush_valid_d;
  logic [TAG_W-1:0]  flush_tag_q, flush_tag_d;
`ifdef ROB_WB_CHECK_EN
  logic              wb_err_q, wb_err_d;
`endif

  logic              retire;
  logic              br_hit;
  logic              alloc_ready;
  logic              alloc_fire;
  logic              is_full;
  logic [TAG_W-1:0]  br_off;
  logic [TAG_W-1:0]  kill_off;

  assign is_full     = (count_q == FULL_CNT);
  assign alloc_ready = reset & ~is_full & ~flush_valid_q;
  // Dispatch may see ready during a mispredict cycle; the write is still dropped.
  assign alloc_fire  = bus.alloc_valid & alloc_ready & ~bus.br_mispredict;
  assign retire      = valid_q[head_q] & done_q[head_q];
  assign br_hit      = bus.br_mispredict & valid_q[bus.br_tag];
  assign br_off      = bus.br_tag - head_q;

  always_comb begin
    valid_d       = valid_q;
    done_d        = done_q;
    has_dest_d    = has_dest_q;
    pd_new_d      = pd_new_q;
    pd_old_d      = pd_old_q;
    pc_d          = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    flush_valid_d = 1'b0;
    flush_tag_d   = flush_tag_q;
    kill_off      = '0;
`ifdef ROB_WB_CHECK_EN
    wb_err_d      = wb_err_q;
`endif

    for (int p = 0; p < NUM_WB; p++) begin
      if (bus.wb_valid[p] && valid_q[bus.wb_tag[p*TAG_W +: TAG_W]]) begin
        done_d[bus.wb_tag[p*TAG_W +: TAG_W]] = 1'b1;
      end
`ifdef ROB_WB_CHECK_EN
      if (bus.wb_valid[p] && (!valid_q[bus.wb_tag[p*TAG_W +: TAG_W]] ||
                              done_q[bus.wb_tag[p*TAG_W +: TAG_W]])) begin
        wb_err_d = 1'b1;
      end
`endif
    end

    if (alloc_fire) begin
      valid_d[tail_q]    = 1'b1;
      done_d[tail_q]     = 1'b0;
      has_dest_d[tail_q] = bus.alloc_has_dest;
      pd_new_d[tail_q]   = bus.alloc_pd_new;
      pd_old_d[tail_q]   = bus.alloc_pd_old;
      pc_d[tail_q]       = bus.alloc_pc;
      tail_d             = tail_q + TAG_W'(1);
    end

    if (retire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + TAG_W'(1);
    end

    // Kill runs last so it overrides a completion landing on a younger entry.
    if (br_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        kill_off = TAG_W'(i) - head_q;
        if ((kill_off > br_off) && ({1'b0, kill_off} < count_q)) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      tail_d        = bus.br_tag + TAG_W'(1);
      count_d       = {1'b0, br_off} + (TAG_W+1)'(1) - (TAG_W+1)'(retire);
      flush_valid_d = 1'b1;
      flush_tag_d   = bus.br_tag;
    end else begin
      count_d = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= '0;
      done_q        <= '0;
      has_dest_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      flush_valid_q <= 1'b0;
      flush_tag_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pd_new_q[i] <= '0;
        pd_old_q[i] <= '0;
        pc_q[i]     <= '0;
      end
`ifdef ROB_WB_CHECK_EN
      wb_err_q      <= 1'b0;
`endif
    end else begin
      valid_q       <= valid_d;
      done_q        <= done_d;
      has_dest_q    <= has_dest_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      flush_valid_q <= flush_valid_d;
      flush_tag_q   <= flush_tag_d;
      for (int i = 0; i < DEPTH; i++) begin
        pd_new_q[i] <= pd_new_d[i];
        pd_old_q[i] <= pd_old_d[i];
        pc_q[i]     <= pc_d[i];
      end
`ifdef ROB_WB_CHECK_EN
      wb_err_q      <= wb_err_d;
`endif
    end
  end

  assign bus.alloc_ready     = alloc_ready;
  assign bus.alloc_tag       = tail_q;
  assign bus.retire_valid    = retire;
  assign bus.retire_has_dest = has_dest_q[head_q];
  assign bus.retire_pd_old   = pd_old_q[head_q];
  assign bus.retire_pd_new   = pd_new_q[head_q];
  assign bus.retire_pc       = pc_q[head_q];
  assign bus.retire_tag      = head_q;
  assign bus.flush_valid     = flush_valid_q;
  assign bus.flush_tag       = flush_tag_q;
  assign bus.head            = head_q;
  assign bus.count           = count_q;
  assign bus.full            = is_full;
  // empty is gated so every output reads 0 while reset is held.
  assign bus.empty           = reset & (count_q == '0);
`ifdef ROB_WB_CHECK_EN
  assign bus.wb_err          = wb_err_q;
`endif
endmodule
`default_nettype wire
